sm83_mem_resp: RTL and testbench
================================

// Module: sm83_mem_resp
// PURPOSE
//  Bus responder at the far end of the SM83 CPU address/data path.
//  - Accepts one CPU access request at a time; decodes its 16-bit address into a memory region.
//  - Services HRAM (FF80-FFFE) and IE (FFFF) internally.
//  - Sequences all other regions onto one external port, with a per-region wait-state count.
//  - Returns read data with a single-cycle acknowledge.
// PARAMETERS
//  WS_WIDTH  3  width of the wait-state counter
//  WS_ROM    1  extra wait cycles, region ROM (0000-7FFF)
//  WS_VRAM   0  extra wait cycles, region VRAM (8000-9FFF)
//  WS_CRAM   1  extra wait cycles, region cart RAM (A000-BFFF)
//  WS_WRAM   0  extra wait cycles, region WRAM (C000-DFFF, echo E000-FDFF)
//  WS_OAM    0  extra wait cycles, region OAM (FE00-FE9F)
//  WS_IO     0  extra wait cycles, region IO (FF00-FF7F)
// PORTS
//  clk         in   1   clock; all state updates on negedge clk
//  reset       in   1   synchronous, active-high reset
//  cpu_req     in   1   single-cycle request pulse
//  cpu_we      in   1   1=write, 0=read; qualified by cpu_req
//  cpu_adr     in   16  access address; qualified by cpu_req
//  cpu_wdata   in   8   write data; qualified by cpu_req
//  cpu_rdata   out  8   read data; valid while cpu_ack
//  cpu_ack     out  1   one-cycle completion pulse
//  cpu_busy    out  1   high from accept until the cycle after ack
//  ext_req     out  1   external access strobe
//  ext_we      out  1   external write
//  ext_region  out  3   region_t code of current access
//  ext_adr     out  16  external address (echo region remapped)
//  ext_wdata   out  8   external write data
//  ext_rdata   in   8   external read data; sampled in last ext_req cycle
//  err_ovr     out  1   sticky: cpu_req dropped while busy
//  dma_active  in   1   OAM DMA in progress (present only with macro)
// BEHAVIOUR
//  - Reset: state IDLE; cpu_rdata=00, cpu_ack=0, cpu_busy=0, ext_*=0, err_ovr=0, IE=00.
//    HRAM contents are not cleared. Reset mid-access aborts it; ext_req low after the reset edge.
//  - FSM states: IDLE, INT (internal), EXT (external), ACK.
//  - IDLE + cpu_req: latch adr, we, wdata, region; set busy.
//    - HRAM, IE, or UNUSABLE region -> INT.
//    - Otherwise -> EXT; load counter with WS_<region>.
//  - INT (1 cycle): perform the access.
//    - UNUSABLE (FEA0-FEFF) reads return FF; writes are dropped.
//    - Go to ACK.
//  - EXT: ext_req held high for WS+1 cycles; counter decrements each cycle.
//    - At count 0: read latches ext_rdata into cpu_rdata; go to ACK.
//  - ACK: cpu_ack=1 for exactly one cycle; busy falls the next cycle; return to IDLE.
//  - Latency, req edge N: internal access ack at N+2; external access ack at N+WS+3.
//  - Echo region: E000-FDFF -> ext_region WRAM, ext_adr = adr-2000 (16-bit wrap not possible).
//  - cpu_req while cpu_busy: request dropped, err_ovr set until reset. The in-flight access is unaffected.
//  - cpu_rdata holds its last value outside ack. ext_adr, ext_we and ext_wdata are stable for the whole ext_req window.
//  - IE: all 8 bits read and write.
// CONFIGURATION
//  SM83_MEM_RESP_DMA_LOCK_EN defined:
//  - dma_active port is present.
//  - While dma_active=1 at accept, any region other than HRAM/IE is treated as UNUSABLE: read FF, write dropped, internal latency.
//  Undefined:
//  - Port absent; no lockout.
// STRUCTURE
//  - Package sm83_mem_pkg: region_t enum (ROM, VRAM, CRAM, WRAM, OAM, UNUSABLE, IO, HRAM, IE), region base/limit constants, ECHO_OFS=16'h2000, state_t enum.
//  - Sub-module sm83_mem_decode: combinational adr -> {region_t, remapped adr}. Reused by the DMA engine.
// TESTING
//  - Reset, then read FFFF -> ack at N+2, rdata 00; all ext_* low.
//  - Write 5A to FF80, then read FF80 -> rdata 5A at N+2; ext_req never asserted.
//  - Read 0150, ext_rdata=C3, WS_ROM=1 -> ext_req high 2 cycles, region ROM, ack at N+4, rdata C3.
//  - Write 77 to E123 -> ext_region WRAM, ext_adr C123, ext_we=1, ext_wdata 77.
//  - Read FEA0 -> rdata FF, no ext_req. With macro and dma_active=1: read C000 -> FF, no ext_req.
//  - cpu_req during EXT -> first access still acks; err_ovr=1. Reset mid-EXT -> ext_req=0 next cycle, err_ovr=0.

Source files
------------

// File: rtl/sm83_mem_pkg.sv
// Shared types and address map for the SM83 memory responder and its decoder.
// Regions, FSM states and the latched access payload live here.
package sm83_mem_pkg;

    localparam int unsigned ADR_W        = 16;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned EXT_REGION_W = 3;
    localparam int unsigned HRAM_DEPTH   = 127;
    localparam int unsigned HRAM_IDX_W   = 7;

    // External regions keep codes below 8 so they fit the 3-bit ext_region bus
    typedef enum logic [3:0] {
        RGN_ROM      = 4'd0,
        RGN_VRAM     = 4'd1,
        RGN_CRAM     = 4'd2,
        RGN_WRAM     = 4'd3,
        RGN_OAM      = 4'd4,
        RGN_UNUSABLE = 4'd5,
        RGN_IO       = 4'd6,
        RGN_HRAM     = 4'd7,
        RGN_IE       = 4'd8
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT  = 2'd1,
        ST_EXT  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam logic [ADR_W-1:0] VRAM_BASE     = 16'h8000;
    localparam logic [ADR_W-1:0] CRAM_BASE     = 16'hA000;
    localparam logic [ADR_W-1:0] WRAM_BASE     = 16'hC000;
    localparam logic [ADR_W-1:0] ECHO_BASE     = 16'hE000;
    localparam logic [ADR_W-1:0] OAM_BASE      = 16'hFE00;
    localparam logic [ADR_W-1:0] UNUSABLE_BASE = 16'hFEA0;
    localparam logic [ADR_W-1:0] IO_BASE       = 16'hFF00;
    localparam logic [ADR_W-1:0] HRAM_BASE     = 16'hFF80;
    localparam logic [ADR_W-1:0] IE_ADR        = 16'hFFFF;
    localparam logic [ADR_W-1:0] ECHO_OFS      = 16'h2000;

    // Request captured at accept; only the HRAM index of the address is kept
    typedef struct packed {
        logic                  we;
        region_t               region;
        logic [HRAM_IDX_W-1:0] hram_idx;
        logic [DATA_W-1:0]     wdata;
    } access_t;

    // Regions serviced without touching the external port
    function automatic logic is_internal(input region_t r);
        return r inside {RGN_HRAM, RGN_IE, RGN_UNUSABLE};
    endfunction

endpackage

// File: rtl/sm83_mem_decode.sv
// Combinational address decoder: CPU address -> region and external address.
// The echo window is folded back onto WRAM here.
module sm83_mem_decode
    import sm83_mem_pkg::*;
(
    input  logic [ADR_W-1:0] adr,
    output region_t          region,
    output logic [ADR_W-1:0] ext_adr
);

    // Highest base first so each branch only needs a lower bound
    always_comb begin
        region  = RGN_ROM;
        ext_adr = adr;
        if (adr == IE_ADR) begin
            region = RGN_IE;
        end else if (adr >= HRAM_BASE) begin
            region = RGN_HRAM;
        end else if (adr >= IO_BASE) begin
            region = RGN_IO;
        end else if (adr >= UNUSABLE_BASE) begin
            region = RGN_UNUSABLE;
        end else if (adr >= OAM_BASE) begin
            region = RGN_OAM;
        end else if (adr >= ECHO_BASE) begin
            region  = RGN_WRAM;
            ext_adr = adr - ECHO_OFS;
        end else if (adr >= WRAM_BASE) begin
            region = RGN_WRAM;
        end else if (adr >= CRAM_BASE) begin
            region = RGN_CRAM;
        end else if (adr >= VRAM_BASE) begin
            region = RGN_VRAM;
        end else begin
            region = RGN_ROM;
        end
    end

endmodule

// File: rtl/sm83_mem_resp.sv
// SM83 bus responder: HRAM/IE served internally, other regions sequenced onto one
// external port with per-region wait states. Optional SM83_MEM_RESP_DMA_LOCK_EN adds OAM-DMA lockout.
module sm83_mem_resp
    import sm83_mem_pkg::*;
#(
    parameter int unsigned WS_WIDTH = 3,
    parameter int unsigned WS_ROM   = 1,
    parameter int unsigned WS_VRAM  = 0,
    parameter int unsigned WS_CRAM  = 1,
    parameter int unsigned WS_WRAM  = 0,
    parameter int unsigned WS_OAM   = 0,
    parameter int unsigned WS_IO    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADR_W-1:0]        cpu_adr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_ack,
    output logic                    cpu_busy,
    output logic                    ext_req,
    output logic                    ext_we,
    output logic [EXT_REGION_W-1:0] ext_region,
    output logic [ADR_W-1:0]        ext_adr,
    output logic [DATA_W-1:0]       ext_wdata,
    input  logic [DATA_W-1:0]       ext_rdata,
    output logic                    err_ovr
`ifdef SM83_MEM_RESP_DMA_LOCK_EN
    ,
    input  logic                    dma_active
`endif
);

    state_t                  state, state_d;
    access_t                 acc, acc_d;
    logic [WS_WIDTH-1:0]     cnt, cnt_d;
    logic [DATA_W-1:0]       ie_q, ie_d;
    logic [DATA_W-1:0]       cpu_rdata_d;
    logic                    cpu_ack_d, cpu_busy_d, ext_req_d, ext_we_d, err_ovr_d;
    logic [EXT_REGION_W-1:0] ext_region_d;
    logic [ADR_W-1:0]        ext_adr_d;
    logic [DATA_W-1:0]       ext_wdata_d;
    logic                    hram_we_c;
    region_t                 dec_region;
    logic [ADR_W-1:0]        dec_adr;
    region_t                 lock_region_c;
    logic [DATA_W-1:0]       hram [HRAM_DEPTH];

    sm83_mem_decode u_decode (
        .adr     (cpu_adr),
        .region  (dec_region),
        .ext_adr (dec_adr)
    );

`ifdef SM83_MEM_RESP_DMA_LOCK_EN
    // During OAM DMA only HRAM and IE stay reachable
    assign lock_region_c = (dma_active && !(dec_region inside {RGN_HRAM, RGN_IE}))
                         ? RGN_UNUSABLE : dec_region;
`else
    assign lock_region_c = dec_region;
`endif

    function automatic logic [WS_WIDTH-1:0] ws_of(input region_t r);
        case (r)
            RGN_ROM:  return WS_WIDTH'(WS_ROM);
            RGN_VRAM: return WS_WIDTH'(WS_VRAM);
            RGN_CRAM: return WS_WIDTH'(WS_CRAM);
            RGN_WRAM: return WS_WIDTH'(WS_WRAM);
            RGN_OAM:  return WS_WIDTH'(WS_OAM);
            RGN_IO:   return WS_WIDTH'(WS_IO);
            default:  return '0;
        endcase
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        cnt_d        = cnt;
        ie_d         = ie_q;
        cpu_rdata_d  = cpu_rdata;
        cpu_ack_d    = 1'b0;
        cpu_busy_d   = cpu_busy;
        ext_req_d    = ext_req;
        ext_we_d     = ext_we;
        ext_region_d = ext_region;
        ext_adr_d    = ext_adr;
        ext_wdata_d  = ext_wdata;
        err_ovr_d    = err_ovr;
        hram_we_c    = 1'b0;

        if (cpu_req && (state != ST_IDLE)) begin
            err_ovr_d = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    acc_d.we       = cpu_we;
                    acc_d.region   = lock_region_c;
                    acc_d.hram_idx = cpu_adr[HRAM_IDX_W-1:0];
                    acc_d.wdata    = cpu_wdata;
                    cpu_busy_d     = 1'b1;
                    if (is_internal(lock_region_c)) begin
                        state_d = ST_INT;
                    end else begin
                        state_d      = ST_EXT;
                        cnt_d        = ws_of(lock_region_c);
                        ext_we_d     = cpu_we;
                        ext_region_d = EXT_REGION_W'(lock_region_c);
                        ext_adr_d    = dec_adr;
                        ext_wdata_d  = cpu_wdata;
                    end
                end
            end
            ST_INT: begin
                state_d   = ST_ACK;
                cpu_ack_d = 1'b1;
                case (acc.region)
                    RGN_HRAM: begin
                        if (acc.we) hram_we_c   = 1'b1;
                        else        cpu_rdata_d = hram[acc.hram_idx];
                    end
                    RGN_IE: begin
                        if (acc.we) ie_d        = acc.wdata;
                        else        cpu_rdata_d = ie_q;
                    end
                    default: begin
                        if (!acc.we) cpu_rdata_d = 8'hFF;
                    end
                endcase
            end
            ST_EXT: begin
                // Address/data are driven one cycle ahead of the strobe
                if (!ext_req) begin
                    ext_req_d = 1'b1;
                end else if (cnt == '0) begin
                    ext_req_d = 1'b0;
                    state_d   = ST_ACK;
                    cpu_ack_d = 1'b1;
                    if (!acc.we) cpu_rdata_d = ext_rdata;
                end else begin
                    cnt_d = cnt - WS_WIDTH'(1);
                end
            end
            ST_ACK: begin
                state_d    = ST_IDLE;
                cpu_busy_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ie_q       <= '0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
            cpu_busy   <= 1'b0;
            ext_req    <= 1'b0;
            ext_we     <= 1'b0;
            ext_region <= '0;
            ext_adr    <= '0;
            ext_wdata  <= '0;
            err_ovr    <= 1'b0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            cnt        <= cnt_d;
            ie_q       <= ie_d;
            cpu_rdata  <= cpu_rdata_d;
            cpu_ack    <= cpu_ack_d;
            cpu_busy   <= cpu_busy_d;
            ext_req    <= ext_req_d;
            ext_we     <= ext_we_d;
            ext_region <= ext_region_d;
            ext_adr    <= ext_adr_d;
            ext_wdata  <= ext_wdata_d;
            err_ovr    <= err_ovr_d;
        end
    end

    // HRAM survives reset
    always_ff @(negedge clk) begin
        if (hram_we_c) begin
            hram[acc.hram_idx] <= acc.wdata;
        end
    end

endmodule

// File: tb/tb_sm83_mem_resp.sv
// Directed bench for sm83_mem_resp; define SM83_MEM_RESP_DMA_LOCK_EN to also cover DMA lockout.
module tb_sm83_mem_resp;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        ext_req;
    logic        ext_we;
    logic [2:0]  ext_region;
    logic [15:0] ext_adr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        err_ovr;
`ifdef SM83_MEM_RESP_DMA_LOCK_EN
    logic        dma_active;
`endif

    int          errors;
    int          checks;

    int          t_ack;
    int          t_ext;
    logic [7:0]  t_rd;
    logic        t_busy_after;
    logic        t_unstable;
    logic [2:0]  t_region;
    logic [15:0] t_adr;
    logic        t_we;
    logic [7:0]  t_wdata;

    sm83_mem_resp #(
        .WS_WIDTH (3), .WS_ROM (1), .WS_VRAM (0), .WS_CRAM (1),
        .WS_WRAM  (0), .WS_OAM (0), .WS_IO   (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_adr    (cpu_adr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_busy   (cpu_busy),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_region (ext_region),
        .ext_adr    (ext_adr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .err_ovr    (err_ovr)
`ifdef SM83_MEM_RESP_DMA_LOCK_EN
        ,
        .dma_active (dma_active)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access; k counts posedges after the request posedge.
    // bump>0 fires a stray write request at that posedge to exercise overrun.
    task automatic access(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                          input int bump);
        @(posedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_adr   = adr;
        cpu_wdata = wd;
        t_ack      = -1;
        t_ext      = 0;
        t_rd       = 8'h00;
        t_unstable = 1'b0;
        for (int k = 1; k <= 24 && t_ack < 0; k++) begin
            @(posedge clk);
            cpu_req = (k == bump);
            if (k == bump) begin
                cpu_adr   = 16'hFF80;
                cpu_we    = 1'b1;
                cpu_wdata = 8'hEE;
            end
            if (ext_req) begin
                if (t_ext == 0) begin
                    t_region = ext_region;
                    t_adr    = ext_adr;
                    t_we     = ext_we;
                    t_wdata  = ext_wdata;
                end else if ({ext_we, ext_region, ext_adr, ext_wdata} !=
                             {t_we, t_region, t_adr, t_wdata}) begin
                    t_unstable = 1'b1;
                end
                t_ext++;
            end
            if (cpu_ack) begin
                t_ack = k;
                t_rd  = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        @(posedge clk);
        t_busy_after = cpu_busy;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_adr   = 16'h0000;
        cpu_wdata = 8'h00;
        ext_rdata = 8'h00;
`ifdef SM83_MEM_RESP_DMA_LOCK_EN
        dma_active = 1'b0;
`endif

        repeat (3) @(posedge clk);
        chk("rst_ack",     32'(cpu_ack), 32'h0);
        chk("rst_busy",    32'(cpu_busy), 32'h0);
        chk("rst_ext_req", 32'(ext_req), 32'h0);
        chk("rst_err_ovr", 32'(err_ovr), 32'h0);
        chk("rst_rdata",   32'(cpu_rdata), 32'h0);
        chk("rst_ext_bus", 32'({ext_we, ext_region, ext_adr, ext_wdata}), 32'h0);
        reset = 1'b0;

        // IE read after reset
        access(1'b0, 16'hFFFF, 8'h00, 0);
        chk("ie_rst_ack",   32'(t_ack), 32'd2);
        chk("ie_rst_rd",    32'(t_rd), 32'h00);
        chk("ie_rst_ext",   32'(t_ext), 32'd0);
        chk("ie_rst_bus",   32'({ext_we, ext_region, ext_adr, ext_wdata}), 32'h0);
        chk("ie_rst_busy",  32'(t_busy_after), 32'h0);

        // HRAM write/read, both ends
        access(1'b1, 16'hFF80, 8'h5A, 0);
        chk("hram_wr_ack", 32'(t_ack), 32'd2);
        access(1'b1, 16'hFFFE, 8'h3C, 0);
        access(1'b0, 16'hFF80, 8'h00, 0);
        chk("hram_lo_rd",  32'(t_rd), 32'h5A);
        chk("hram_lo_ack", 32'(t_ack), 32'd2);
        chk("hram_ext",    32'(t_ext), 32'd0);
        access(1'b0, 16'hFFFE, 8'h00, 0);
        chk("hram_hi_rd",  32'(t_rd), 32'h3C);

        // IE full 8-bit write/read
        access(1'b1, 16'hFFFF, 8'hA5, 0);
        access(1'b0, 16'hFFFF, 8'h00, 0);
        chk("ie_rd", 32'(t_rd), 32'hA5);

        // ROM read, 1 wait state
        ext_rdata = 8'hC3;
        access(1'b0, 16'h0150, 8'h00, 0);
        chk("rom_ack",    32'(t_ack), 32'd4);
        chk("rom_ext",    32'(t_ext), 32'd2);
        chk("rom_rd",     32'(t_rd), 32'hC3);
        chk("rom_region", 32'(t_region), 32'd0);
        chk("rom_adr",    32'(t_adr), 32'h0150);
        chk("rom_we",     32'(t_we), 32'h0);
        chk("rom_stable", 32'(t_unstable), 32'h0);
        chk("rom_busy",   32'(t_busy_after), 32'h0);

        // Echo write lands in WRAM
        access(1'b1, 16'hE123, 8'h77, 0);
        chk("echo_region", 32'(t_region), 32'd3);
        chk("echo_adr",    32'(t_adr), 32'hC123);
        chk("echo_we",     32'(t_we), 32'h1);
        chk("echo_wdata",  32'(t_wdata), 32'h77);
        chk("echo_ext",    32'(t_ext), 32'd1);
        chk("echo_ack",    32'(t_ack), 32'd3);

        ext_rdata = 8'h5E;
        access(1'b0, 16'hFDFF, 8'h00, 0);
        chk("echo_top_adr", 32'(t_adr), 32'hDDFF);
        chk("echo_top_rd",  32'(t_rd), 32'h5E);

        // Region boundaries
        access(1'b0, 16'hA000, 8'h00, 0);
        chk("cram_region", 32'(t_region), 32'd2);
        chk("cram_ack",    32'(t_ack), 32'd4);
        access(1'b0, 16'h9FFF, 8'h00, 0);
        chk("vram_region", 32'(t_region), 32'd1);
        chk("vram_ack",    32'(t_ack), 32'd3);
        access(1'b0, 16'hFE9F, 8'h00, 0);
        chk("oam_region",  32'(t_region), 32'd4);
        access(1'b0, 16'hFF00, 8'h00, 0);
        chk("io_lo_region", 32'(t_region), 32'd6);
        access(1'b0, 16'hFF7F, 8'h00, 0);
        chk("io_hi_region", 32'(t_region), 32'd6);
        chk("io_hi_ack",    32'(t_ack), 32'd3);

        // Unusable window
        access(1'b0, 16'hFEA0, 8'h00, 0);
        chk("unus_rd",   32'(t_rd), 32'hFF);
        chk("unus_ext",  32'(t_ext), 32'd0);
        chk("unus_ack",  32'(t_ack), 32'd2);
        chk("rd_hold",   32'(cpu_rdata), 32'hFF);
        access(1'b1, 16'hFEFF, 8'h12, 0);
        chk("unus_wr_ext", 32'(t_ext), 32'd0);
        chk("unus_wr_ack", 32'(t_ack), 32'd2);

`ifdef SM83_MEM_RESP_DMA_LOCK_EN
        dma_active = 1'b1;
        ext_rdata  = 8'h99;
        access(1'b0, 16'hC000, 8'h00, 0);
        chk("dma_rd",  32'(t_rd), 32'hFF);
        chk("dma_ext", 32'(t_ext), 32'd0);
        chk("dma_ack", 32'(t_ack), 32'd2);
        access(1'b0, 16'hFF80, 8'h00, 0);
        chk("dma_hram_rd", 32'(t_rd), 32'h5A);
        dma_active = 1'b0;
`endif

        // Overrun during an external access
        chk("pre_ovr_err", 32'(err_ovr), 32'h0);
        ext_rdata = 8'hC3;
        access(1'b0, 16'h0150, 8'h00, 2);
        chk("ovr_ack",    32'(t_ack), 32'd4);
        chk("ovr_rd",     32'(t_rd), 32'hC3);
        chk("ovr_stable", 32'(t_unstable), 32'h0);
        chk("ovr_err",    32'(err_ovr), 32'h1);
        access(1'b0, 16'hFF80, 8'h00, 0);
        chk("ovr_dropped", 32'(t_rd), 32'h5A);
        chk("ovr_sticky",  32'(err_ovr), 32'h1);

        // Reset in the middle of an external access
        @(posedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 16'h0150;
        @(posedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        chk("mid_ext_req", 32'(ext_req), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        chk("abort_ext_req", 32'(ext_req), 32'h0);
        chk("abort_err",     32'(err_ovr), 32'h0);
        chk("abort_busy",    32'(cpu_busy), 32'h0);
        access(1'b0, 16'hFFFF, 8'h00, 0);
        chk("abort_ie_rd",   32'(t_rd), 32'h00);
        access(1'b0, 16'hFF80, 8'h00, 0);
        chk("abort_hram_rd", 32'(t_rd), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
